// File: rtl/inst_uart_loader_if.sv
// Instruction-memory load bus between the UART loader and its environment.
// The loader side is the master: it consumes en/rxd and drives the write port and status.
interface inst_uart_loader_if #(
    parameter int ADDR_W = 14
);
    logic              en;
    logic              rxd;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   word_count;

    modport master (
        input  en, rxd,
        output we, waddr, wdata, done, err, word_count
    );

    modport slave (
        output en, rxd,
        input  we, waddr, wdata, done, err, word_count
    );
endinterface

// File: rtl/inst_uart_loader.sv
// UART (8N1, LSB-first) program loader: packs received bytes big-endian into 32-bit words
// and writes them to consecutive instruction-memory addresses until the end marker arrives.
module inst_uart_loader #(
    parameter int          CLK_PER_HALF_BIT = 434,
    parameter int          ADDR_W           = 14,
    parameter logic [31:0] END_WORD         = 32'h0000_003F
) (
    input  logic                clk,
    input  logic                rstn,
    inst_uart_loader_if.master  bus
);
    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CNT_W   = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [ADDR_W:0]   MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_e;

    logic [1:0]        sync_q;
    logic              rxs;
    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bi_q, bi_d;
    logic [7:0]        sh_q, sh_d;
    logic              byte_valid_q, byte_valid_d;
    logic              frame_err;

    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;
    logic              word_rdy_q, word_rdy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W:0]   wc_q, wc_d;

    assign rxs = sync_q[1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bi_d         = bi_q;
        sh_d         = sh_q;
        byte_valid_d = 1'b0;
        frame_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = S_START;
            end
            S_START: begin
                // Mid-start-bit re-check rejects short glitches on the line.
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bi_d    = 3'd0;
                    state_d = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs, sh_q[7:1]};
                    if (bi_q == 3'd7) state_d = S_STOP;
                    else              bi_d    = bi_q + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_IDLE;
                    byte_valid_d = rxs;
                    frame_err    = !rxs;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bidx_d     = bidx_q;
        word_d     = word_q;
        word_rdy_d = 1'b0;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        err_d      = err_q | frame_err;
        wc_d       = wc_q;
        if (!bus.en) begin
            bidx_d = 2'd0;
        end else if (byte_valid_q && !done_q) begin
            word_d     = {word_q[23:0], sh_q};
            bidx_d     = bidx_q + 2'd1;
            word_rdy_d = (bidx_q == 2'd3);
        end
        // A completed word is acted on one cycle after its last byte is absorbed.
        if (word_rdy_q && bus.en && !done_q) begin
            if (word_q == END_WORD) begin
                done_d = 1'b1;
            end else if (wc_q == MEM_WORDS) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                waddr_d = wc_q[ADDR_W-1:0];
                wdata_d = word_q;
                wc_d    = wc_q + (ADDR_W+1)'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q       <= 2'b11;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bi_q         <= 3'd0;
            sh_q         <= 8'd0;
            byte_valid_q <= 1'b0;
            bidx_q       <= 2'd0;
            word_q       <= 32'd0;
            word_rdy_q   <= 1'b0;
            we_q         <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= 32'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wc_q         <= '0;
        end else begin
            sync_q       <= {sync_q[0], bus.rxd};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bi_q         <= bi_d;
            sh_q         <= sh_d;
            byte_valid_q <= byte_valid_d;
            bidx_q       <= bidx_d;
            word_q       <= word_d;
            word_rdy_q   <= word_rdy_d;
            we_q         <= we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            wc_q         <= wc_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = wc_q;
endmodule

// File: tb/tb_inst_uart_loader.sv
// Self-checking bench: two loaders (ADDR_W=14 and ADDR_W=2) share one UART line and are
// compared against a word-level reference model of the load protocol.
module tb_inst_uart_loader;
    localparam int          H        = 4;
    localparam logic [31:0] END_WORD = 32'h0000_003F;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic rxd = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    wr_t         exp_q[2][$];
    wr_t         act_q[2][$];
    int          m_count[2];
    int          m_idx[2];
    logic [31:0] m_word[2];
    bit          m_done[2];
    bit          m_err[2];
    int          m_cap[2] = '{1 << 14, 4};

    inst_uart_loader_if #(.ADDR_W(14)) bus_a ();
    inst_uart_loader_if #(.ADDR_W(2))  bus_b ();

    assign bus_a.rxd = rxd;
    assign bus_a.en  = en_a;
    assign bus_b.rxd = rxd;
    assign bus_b.en  = en_b;

    inst_uart_loader #(.CLK_PER_HALF_BIT(H), .ADDR_W(14), .END_WORD(END_WORD)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    inst_uart_loader #(.CLK_PER_HALF_BIT(H), .ADDR_W(2), .END_WORD(END_WORD)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.we) act_q[0].push_back('{cyc, int'(bus_a.waddr), bus_a.wdata});
        if (bus_b.we) act_q[1].push_back('{cyc, int'(bus_b.waddr), bus_b.wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: one received frame, applied to both loaders.
    function automatic void model_byte(input logic [7:0] b, input bit stop_ok, input int tstart);
        for (int d = 0; d < 2; d++) begin
            bit en_d = (d == 0) ? en_a : en_b;
            if (!stop_ok) begin
                m_err[d] = 1'b1;
            end else if (en_d && !m_done[d]) begin
                m_word[d] = (m_word[d] << 8) | 32'(b);
                m_idx[d]++;
                if (m_idx[d] == 4) begin
                    m_idx[d] = 0;
                    if (m_word[d] == END_WORD)       m_done[d] = 1'b1;
                    else if (m_count[d] == m_cap[d]) m_err[d]  = 1'b1;
                    else begin
                        // Stop sample lands 2+19H cycles after the start edge; write 2 later.
                        exp_q[d].push_back('{tstart + 4 + 19 * H, m_count[d], m_word[d]});
                        m_count[d]++;
                    end
                end
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
        int ts;
        logic [7:0] v;
        v = b;
        @(negedge clk);
        ts  = cyc + 1;
        rxd = 1'b0;
        repeat (2 * H) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            repeat (2 * H) @(negedge clk);
        end
        rxd = stop_ok;
        repeat (2 * H) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        model_byte(v, stop_ok, ts);
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] v;
        v = w;
        send_byte(v[31:24]);
        send_byte(v[23:16]);
        send_byte(v[15:8]);
        send_byte(v[7:0]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        do w = $urandom; while (w == END_WORD);
        return w;
    endfunction

    task automatic check_dut(input int d, input string tag);
        int n;
        chk({tag, "_nwr"}, 64'(act_q[d].size()), 64'(exp_q[d].size()));
        n = (act_q[d].size() < exp_q[d].size()) ? act_q[d].size() : exp_q[d].size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 64'(act_q[d][i].addr), 64'(exp_q[d][i].addr));
            chk({tag, "_data"}, 64'(act_q[d][i].data), 64'(exp_q[d][i].data));
            chk({tag, "_lat"},  64'(act_q[d][i].cyc),  64'(exp_q[d][i].cyc));
        end
        act_q[d].delete();
        exp_q[d].delete();
        if (d == 0) begin
            chk({tag, "_wc"},   64'(bus_a.word_count), 64'(m_count[0]));
            chk({tag, "_done"}, 64'(bus_a.done),       64'(m_done[0]));
            chk({tag, "_err"},  64'(bus_a.err),        64'(m_err[0]));
        end else begin
            chk({tag, "_wc"},   64'(bus_b.word_count), 64'(m_count[1]));
            chk({tag, "_done"}, 64'(bus_b.done),       64'(m_done[1]));
            chk({tag, "_err"},  64'(bus_b.err),        64'(m_err[1]));
        end
    endtask

    task automatic do_reset();
        en_a = 1'b0;
        en_b = 1'b0;
        rxd  = 1'b1;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we",    64'(bus_a.we),         64'(0));
        chk("rst_waddr", 64'(bus_a.waddr),      64'(0));
        chk("rst_wdata", 64'(bus_a.wdata),      64'(0));
        chk("rst_done",  64'(bus_a.done),       64'(0));
        chk("rst_err",   64'(bus_a.err),        64'(0));
        chk("rst_wc",    64'(bus_a.word_count), 64'(0));
        chk("rst_b_wc",  64'(bus_b.word_count), 64'(0));
        for (int d = 0; d < 2; d++) begin
            m_count[d] = 0;
            m_idx[d]   = 0;
            m_word[d]  = 32'd0;
            m_done[d]  = 1'b0;
            m_err[d]   = 1'b0;
            exp_q[d].delete();
            act_q[d].delete();
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset, then an idle line must never produce a write.
        do_reset();
        en_a = 1'b1;
        repeat (100) @(negedge clk);
        check_dut(0, "idle");

        // Two directed words, a random one, then the end marker and trailing bytes.
        send_word(32'h1234_5678);
        check_dut(0, "w0");
        send_word(32'h9ABC_DEF0);
        check_dut(0, "w1");
        send_word(rand_word());
        check_dut(0, "w2");
        send_word(END_WORD);
        check_dut(0, "end");
        send_word(32'h1122_3344);
        check_dut(0, "post_done");

        // Framing error, recovery, then en dropped mid-word.
        do_reset();
        en_a = 1'b1;
        send_byte(8'hAA, 1'b0);
        check_dut(0, "ferr");
        send_word(32'hABCD_EF01);
        check_dut(0, "after_ferr");
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        en_a = 1'b0;
        m_idx[0] = 0;
        @(negedge clk);
        en_a = 1'b1;
        send_word(32'h0102_0304);
        check_dut(0, "en_drop");
        for (int i = 0; i < 3; i++) begin
            send_word(rand_word());
            check_dut(0, "rand");
        end

        // Small memory: glitch rejection, fill, then overflow.
        do_reset();
        en_b = 1'b1;
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (4 * H) @(negedge clk);
        check_dut(1, "glitch");
        for (int i = 0; i < 4; i++) begin
            send_word(rand_word());
            check_dut(1, "fill");
        end
        send_word(rand_word());
        check_dut(1, "overflow");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
